// File: rtl/dut_response_capture.sv
// Receive-side pin capture: strobes synchronized DUT pins once per test cycle and
// compares them against double-buffered expected/mask vectors. Fail statistics are kept per run.
module dut_response_capture #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               PERFORM_TEST,
   input  logic [127:0]       BUS128_0,
   input  logic               EXP_LOAD,
   input  logic               EXP_TRANSFER,
   input  logic               MASK_LOAD,
   input  logic               MASK_TRANSFER,
   input  logic [6:0]         STROBE_EDGE,
   input  logic [7:0]         CYCLE_LENGTH,
   input  logic [127:0]       DUT_SIGNALS,
   output logic [127:0]       CAPTURE,
   output logic               RESULT_VALID,
   output logic               CYCLE_FAIL,
   output logic [127:0]       FAIL_VEC,
   output logic               ANY_FAIL,
   output logic [CNT_W-1:0]   CYCLE_COUNT,
   output logic [CNT_W-1:0]   FAIL_COUNT,
   output logic [CNT_W-1:0]   FIRST_FAIL_CYCLE
);

   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [SYNC_N-1:0][127:0] sync_reg;
   logic [127:0]             exp_pre_reg, exp_act_reg, mask_pre_reg, mask_act_reg;
   logic [127:0]             capture_reg, exp_l_reg, mask_l_reg, fail_vec_reg;
   logic [7:0]               phase_reg;
   logic                     pt_d_reg, cmp_pending_reg, result_valid_reg, cycle_fail_reg;
   logic [CNT_W-1:0]         cycle_count_reg, fail_count_reg, first_fail_reg;

   logic [7:0]   last_phase;
   logic         run_start, strobe;
   logic [127:0] mism;

   // CYCLE_LENGTH of 0 wraps to 255 here, giving the 256-CLK cycle for free.
   assign last_phase = CYCLE_LENGTH - 8'd1;
   assign run_start  = PERFORM_TEST & ~pt_d_reg;
   assign strobe     = PERFORM_TEST & (phase_reg == {1'b0, STROBE_EDGE});
   assign mism       = (capture_reg ^ exp_l_reg) & mask_l_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_reg         <= '0;
         exp_pre_reg      <= '0;
         exp_act_reg      <= '0;
         mask_pre_reg     <= '0;
         mask_act_reg     <= '0;
         capture_reg      <= '0;
         exp_l_reg        <= '0;
         mask_l_reg       <= '0;
         fail_vec_reg     <= '0;
         phase_reg        <= '0;
         pt_d_reg         <= 1'b0;
         cmp_pending_reg  <= 1'b0;
         result_valid_reg <= 1'b0;
         cycle_fail_reg   <= 1'b0;
         cycle_count_reg  <= '0;
         fail_count_reg   <= '0;
         first_fail_reg   <= '1;
      end else begin
         sync_reg <= {sync_reg[SYNC_N-2:0], DUT_SIGNALS};
         pt_d_reg <= PERFORM_TEST;

         // Transfer reads the pre-buffer before this edge's load lands.
         if (EXP_LOAD)      exp_pre_reg  <= BUS128_0;
         if (EXP_TRANSFER)  exp_act_reg  <= exp_pre_reg;
         if (MASK_LOAD)     mask_pre_reg <= BUS128_0;
         if (MASK_TRANSFER) mask_act_reg <= mask_pre_reg;

         if (!PERFORM_TEST || phase_reg == last_phase)
            phase_reg <= '0;
         else
            phase_reg <= phase_reg + 8'd1;

         if (strobe) begin
            capture_reg <= sync_reg[SYNC_N-1];
            exp_l_reg   <= exp_act_reg;
            mask_l_reg  <= mask_act_reg;
         end

         cmp_pending_reg  <= strobe;
         result_valid_reg <= cmp_pending_reg;
         if (cmp_pending_reg)
            cycle_fail_reg <= |mism;

         if (run_start) begin
            fail_vec_reg    <= '0;
            cycle_count_reg <= '0;
            fail_count_reg  <= '0;
            first_fail_reg  <= '1;
         end else if (cmp_pending_reg) begin
            fail_vec_reg <= fail_vec_reg | mism;
            if (cycle_count_reg != '1)
               cycle_count_reg <= cycle_count_reg + CNT_ONE;
            if (|mism) begin
               if (fail_count_reg != '1)
                  fail_count_reg <= fail_count_reg + CNT_ONE;
               if (first_fail_reg == '1)
                  first_fail_reg <= cycle_count_reg;
            end
         end
      end
   end

   assign CAPTURE          = capture_reg;
   assign RESULT_VALID     = result_valid_reg;
   assign CYCLE_FAIL       = cycle_fail_reg;
   assign FAIL_VEC         = fail_vec_reg;
   assign ANY_FAIL         = |fail_vec_reg;
   assign CYCLE_COUNT      = cycle_count_reg;
   assign FAIL_COUNT       = fail_count_reg;
   assign FIRST_FAIL_CYCLE = first_fail_reg;

endmodule

// File: tb/tb_dut_response_capture.sv
// Directed bench for dut_response_capture: a default-width instance plus a CNT_W=4
// instance on the same stimulus for counter saturation.
module tb_dut_response_capture;

   logic         CLK = 1'b0;
   logic         RST, PERFORM_TEST, EXP_LOAD, EXP_TRANSFER, MASK_LOAD, MASK_TRANSFER;
   logic [127:0] BUS128_0, DUT_SIGNALS;
   logic [6:0]   STROBE_EDGE;
   logic [7:0]   CYCLE_LENGTH;

   logic [127:0] CAPTURE, FAIL_VEC;
   logic         RESULT_VALID, CYCLE_FAIL, ANY_FAIL;
   logic [15:0]  CYCLE_COUNT, FAIL_COUNT, FIRST_FAIL_CYCLE;

   logic [127:0] s_capture, s_fail_vec;
   logic         s_result_valid, s_cycle_fail, s_any_fail;
   logic [3:0]   s_cycle_count, s_fail_count, s_first_fail;

   int vectors = 0;
   int miscompares = 0;
   logic [127:0] pins_base, a5, n5a, ones, mask100, flip;

   always #5 CLK = ~CLK;

   dut_response_capture #(.SYNC_STAGES(2), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .PERFORM_TEST(PERFORM_TEST), .BUS128_0(BUS128_0),
      .EXP_LOAD(EXP_LOAD), .EXP_TRANSFER(EXP_TRANSFER),
      .MASK_LOAD(MASK_LOAD), .MASK_TRANSFER(MASK_TRANSFER),
      .STROBE_EDGE(STROBE_EDGE), .CYCLE_LENGTH(CYCLE_LENGTH), .DUT_SIGNALS(DUT_SIGNALS),
      .CAPTURE(CAPTURE), .RESULT_VALID(RESULT_VALID), .CYCLE_FAIL(CYCLE_FAIL),
      .FAIL_VEC(FAIL_VEC), .ANY_FAIL(ANY_FAIL), .CYCLE_COUNT(CYCLE_COUNT),
      .FAIL_COUNT(FAIL_COUNT), .FIRST_FAIL_CYCLE(FIRST_FAIL_CYCLE)
   );

   dut_response_capture #(.SYNC_STAGES(2), .CNT_W(4)) dut_small (
      .CLK(CLK), .RST(RST), .PERFORM_TEST(PERFORM_TEST), .BUS128_0(BUS128_0),
      .EXP_LOAD(EXP_LOAD), .EXP_TRANSFER(EXP_TRANSFER),
      .MASK_LOAD(MASK_LOAD), .MASK_TRANSFER(MASK_TRANSFER),
      .STROBE_EDGE(STROBE_EDGE), .CYCLE_LENGTH(CYCLE_LENGTH), .DUT_SIGNALS(DUT_SIGNALS),
      .CAPTURE(s_capture), .RESULT_VALID(s_result_valid), .CYCLE_FAIL(s_cycle_fail),
      .FAIL_VEC(s_fail_vec), .ANY_FAIL(s_any_fail), .CYCLE_COUNT(s_cycle_count),
      .FAIL_COUNT(s_fail_count), .FIRST_FAIL_CYCLE(s_first_fail)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic load_exp(input logic [127:0] v, input bit xfer);
      BUS128_0 = v; EXP_LOAD = 1'b1; tick(); EXP_LOAD = 1'b0;
      if (xfer) begin EXP_TRANSFER = 1'b1; tick(); EXP_TRANSFER = 1'b0; end
   endtask

   task automatic load_mask(input logic [127:0] v, input bit xfer);
      BUS128_0 = v; MASK_LOAD = 1'b1; tick(); MASK_LOAD = 1'b0;
      if (xfer) begin MASK_TRANSFER = 1'b1; tick(); MASK_TRANSFER = 1'b0; end
   endtask

   // One run of n_cyc test cycles; pins are flipped for the whole of cycle fail_cyc.
   // Results are expected se+1 CLKs after each cycle start.
   task automatic run_cycles(input string tag, input int n_cyc, input int len, input int se,
                             input int fail_cyc, input bit all_fail,
                             input logic [127:0] flp, input int xfer_k);
      int  c;
      bit  exp_valid, exp_fail;
      CYCLE_LENGTH = len[7:0];
      STROBE_EDGE  = se[6:0];
      PERFORM_TEST = 1'b1;
      for (int k = 0; k < n_cyc * len; k++) begin
         c = k / len;
         DUT_SIGNALS  = (fail_cyc >= 0 && c == fail_cyc) ? (pins_base ^ flp) : pins_base;
         EXP_TRANSFER = (k == xfer_k);
         tick();
         if (k == 0) begin
            chk({tag, " start cycle_count"}, CYCLE_COUNT, 0);
            chk({tag, " start fail_vec"}, FAIL_VEC, 0);
         end
         exp_valid = (se + 1 < len) && (k % len == se + 1);
         chk({tag, " result_valid"}, RESULT_VALID, exp_valid);
         if (exp_valid) begin
            exp_fail = all_fail || (c == fail_cyc);
            chk({tag, " cycle_fail"}, CYCLE_FAIL, exp_fail);
         end
      end
      EXP_TRANSFER = 1'b0;
      DUT_SIGNALS  = pins_base;
      PERFORM_TEST = 1'b0;
      tick();
   endtask

   initial begin
      a5      = {16{8'hA5}};
      n5a     = {16{8'h5A}};
      ones    = '1;
      mask100 = ones;
      mask100[100] = 1'b0;
      flip    = '0;
      flip[7] = 1'b1;
      flip[100] = 1'b1;

      // Reset with the run enabled and random pins
      RST = 1'b1; PERFORM_TEST = 1'b1;
      EXP_LOAD = 1'b0; EXP_TRANSFER = 1'b0; MASK_LOAD = 1'b0; MASK_TRANSFER = 1'b0;
      BUS128_0 = '0; CYCLE_LENGTH = 8'd10; STROBE_EDGE = 7'd4;
      DUT_SIGNALS = {$urandom, $urandom, $urandom, $urandom};
      pins_base = a5;
      tick(); tick();
      chk("rst capture", CAPTURE, 0);
      chk("rst result_valid", RESULT_VALID, 0);
      chk("rst cycle_fail", CYCLE_FAIL, 0);
      chk("rst fail_vec", FAIL_VEC, 0);
      chk("rst any_fail", ANY_FAIL, 0);
      chk("rst cycle_count", CYCLE_COUNT, 0);
      chk("rst fail_count", FAIL_COUNT, 0);
      chk("rst first_fail", FIRST_FAIL_CYCLE, 16'hFFFF);
      chk("rst small first_fail", s_first_fail, 4'hF);
      chk("rst small result_valid", s_result_valid, 0);
      chk("rst small cycle_fail", s_cycle_fail, 0);

      RST = 1'b0; PERFORM_TEST = 1'b0; DUT_SIGNALS = pins_base;
      load_exp(a5, 1'b1);
      load_mask(ones, 1'b1);
      tick();

      run_cycles("pass", 5, 10, 4, -1, 1'b0, '0, -1);
      chk("pass cycle_count", CYCLE_COUNT, 5);
      chk("pass fail_count", FAIL_COUNT, 0);
      chk("pass any_fail", ANY_FAIL, 0);
      chk("pass first_fail", FIRST_FAIL_CYCLE, 16'hFFFF);
      chk("pass capture", CAPTURE, a5);

      load_mask(mask100, 1'b1);
      run_cycles("masked", 5, 10, 4, 2, 1'b0, flip, -1);
      chk("masked fail_vec", FAIL_VEC, 128'h80);
      chk("masked fail_count", FAIL_COUNT, 1);
      chk("masked first_fail", FIRST_FAIL_CYCLE, 2);
      chk("masked cycle_count", CYCLE_COUNT, 5);
      chk("masked any_fail", ANY_FAIL, 1);

      run_cycles("len256", 2, 256, 127, -1, 1'b0, '0, -1);
      chk("len256 cycle_count", CYCLE_COUNT, 2);
      chk("len256 fail_count", FAIL_COUNT, 0);

      run_cycles("nostrobe", 5, 4, 5, -1, 1'b0, '0, -1);
      chk("nostrobe cycle_count", CYCLE_COUNT, 0);

      // Transfer of a new expected on the strobe cycle applies from the next cycle
      load_mask(ones, 1'b1);
      load_exp(n5a, 1'b0);
      run_cycles("xfer_strobe", 2, 10, 4, 1, 1'b0, '0, 4);
      chk("xfer_strobe fail_vec", FAIL_VEC, ones);
      chk("xfer_strobe first_fail", FIRST_FAIL_CYCLE, 1);
      chk("xfer_strobe fail_count", FAIL_COUNT, 1);

      // LOAD+TRANSFER together: active takes the old pre-buffer (a5)
      load_exp(a5, 1'b0);
      BUS128_0 = n5a; EXP_LOAD = 1'b1; EXP_TRANSFER = 1'b1; tick();
      EXP_LOAD = 1'b0; EXP_TRANSFER = 1'b0;
      run_cycles("ld_xfer", 1, 10, 4, -1, 1'b0, '0, -1);
      chk("ld_xfer fail_count", FAIL_COUNT, 0);
      chk("ld_xfer cycle_count", CYCLE_COUNT, 1);
      EXP_TRANSFER = 1'b1; tick(); EXP_TRANSFER = 1'b0;
      run_cycles("xfer_new", 1, 10, 4, 0, 1'b0, '0, -1);
      chk("xfer_new fail_count", FAIL_COUNT, 1);
      chk("xfer_new first_fail", FIRST_FAIL_CYCLE, 0);

      run_cycles("sat", 20, 2, 0, -1, 1'b1, '0, -1);
      chk("sat fail_count", FAIL_COUNT, 20);
      chk("sat cycle_count", CYCLE_COUNT, 20);
      chk("sat small fail_count", s_fail_count, 4'hF);
      chk("sat small cycle_count", s_cycle_count, 4'hF);
      chk("sat small first_fail", s_first_fail, 0);
      chk("sat small fail_vec", s_fail_vec, ones);
      chk("sat small any_fail", s_any_fail, 1);
      chk("sat small capture", s_capture, a5);

      // Mid-run reset clears everything, buffers included
      CYCLE_LENGTH = 8'd10; STROBE_EDGE = 7'd4; PERFORM_TEST = 1'b1;
      for (int k = 0; k < 25; k++) tick();
      chk("midrun fail_count", FAIL_COUNT, 2);
      RST = 1'b1; tick();
      chk("midrst capture", CAPTURE, 0);
      chk("midrst fail_vec", FAIL_VEC, 0);
      chk("midrst cycle_count", CYCLE_COUNT, 0);
      chk("midrst fail_count", FAIL_COUNT, 0);
      chk("midrst first_fail", FIRST_FAIL_CYCLE, 16'hFFFF);
      chk("midrst result_valid", RESULT_VALID, 0);
      RST = 1'b0;
      run_cycles("postrst", 1, 10, 4, -1, 1'b0, '0, -1);
      chk("postrst cycle_count", CYCLE_COUNT, 1);
      chk("postrst fail_count", FAIL_COUNT, 0);
      chk("postrst capture", CAPTURE, a5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dut_response_capture.md
Name: dut_response_capture

Overview:
- Receive side of the DUT pin interface: samples the 128 DUT pins once per test cycle at a programmable strobe edge.
- Compares the sample against a double-buffered expected vector under a double-buffered compare mask.
- Accumulates per-pin sticky failures, a fail count and the first failing cycle index.
- Sits beside the drive-side controller and shares its test-cycle timing (PERFORM_TEST, cycle length) and LOAD/TRANSFER double-buffer scheme.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on DUT_SIGNALS before the strobe sampler (min 2).
- CNT_W, 16, width of cycle/fail counters.

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous, active-high reset
- PERFORM_TEST  input  1  test run enable; rising edge starts a new run
- BUS128_0  input  128  load bus for expected and mask vectors
- EXP_LOAD  input  1  BUS128_0 -> expected pre-buffer
- EXP_TRANSFER  input  1  expected pre-buffer -> active expected
- MASK_LOAD  input  1  BUS128_0 -> mask pre-buffer
- MASK_TRANSFER  input  1  mask pre-buffer -> active mask (1 = compare pin)
- STROBE_EDGE  input  7  phase within test cycle at which pins are sampled
- CYCLE_LENGTH  input  8  test cycle period in CLKs (0 means 256)
- DUT_SIGNALS  input  128  DUT pin values (asynchronous to CLK)
- CAPTURE  output  128  last strobed sample
- RESULT_VALID  output  1  one-CLK pulse when a compare result is available
- CYCLE_FAIL  output  1  compare result of current cycle (valid with RESULT_VALID)
- FAIL_VEC  output  128  sticky per-pin failure bits for the run
- ANY_FAIL  output  1  OR of FAIL_VEC
- CYCLE_COUNT  output  CNT_W  number of strobed cycles this run
- FAIL_COUNT  output  CNT_W  number of failing cycles this run
- FIRST_FAIL_CYCLE  output  CNT_W  CYCLE_COUNT index of first failing cycle; all-ones if none

Behaviour:
- Reset (RST=1 at CLK edge): all pre-buffers, active buffers, CAPTURE, FAIL_VEC and counters = 0; FIRST_FAIL_CYCLE = all-ones; RESULT_VALID = CYCLE_FAIL = ANY_FAIL = 0; phase = 0; synchronizer flops = 0. Reset overrides all other inputs, including mid-run.
- Double buffers (expected and mask, independent): LOAD writes pre-buffer; TRANSFER copies pre-buffer to active. LOAD and TRANSFER in the same cycle: active gets the OLD pre-buffer, pre-buffer gets the bus. Buffers operate regardless of PERFORM_TEST.
- Synchronizer: DUT_SIGNALS passes through SYNC_STAGES flops; sampled value = synchronizer output (pin-to-sample latency SYNC_STAGES CLKs).
- Phase counter: runs only while PERFORM_TEST=1; counts 0..N-1, N = CYCLE_LENGTH (0 -> 256), wraps to 0. PERFORM_TEST=0 holds phase at 0. A CYCLE_LENGTH change takes effect at the next wrap comparison.
- Run start: the cycle in which PERFORM_TEST rises (previous 0, now 1) clears FAIL_VEC, CYCLE_COUNT and FAIL_COUNT and sets FIRST_FAIL_CYCLE = all-ones. Phase 0 is that same cycle.
- Strobe: when PERFORM_TEST=1 and phase == STROBE_EDGE, CAPTURE <= synchronized pins; the active expected and mask at that edge are latched with it. A TRANSFER on the strobe cycle is NOT used for this strobe. STROBE_EDGE >= N means no strobe and no results.
- Compare (one CLK after strobe):
  - mism = (CAPTURE ^ exp_l) & mask_l.
  - RESULT_VALID = 1 for one CLK; CYCLE_FAIL = |mism.
  - FAIL_VEC |= mism.
  - CYCLE_COUNT += 1.
  - If CYCLE_FAIL: FAIL_COUNT += 1, and if FIRST_FAIL_CYCLE is all-ones it takes the pre-increment CYCLE_COUNT.
  - Counters saturate at all-ones (no wrap).
- Strobe-to-RESULT_VALID latency: 1 CLK. Pin-to-result latency: SYNC_STAGES+1 CLKs from the strobe-relevant pin value.
- PERFORM_TEST falling: phase goes to 0. A compare pending from a strobe in the last active cycle still completes. Results hold until the next run start or reset.
- ANY_FAIL is combinational from FAIL_VEC.

Test Plan:
- Reset: assert RST for 2 CLKs with PERFORM_TEST=1, random pins -> all outputs 0, FIRST_FAIL_CYCLE=16'hFFFF, no RESULT_VALID.
- Pass run: expected=mask-applied pin pattern 0xA5..A5, mask=all-ones, CYCLE_LENGTH=10, STROBE_EDGE=4, pins stable, 5 cycles -> 5 RESULT_VALID pulses spaced 10 CLKs, each 5 CLKs after the cycle start, CYCLE_COUNT=5, FAIL_COUNT=0, ANY_FAIL=0.
- Masked fail: flip pin 7 and pin 100 in cycle 2, mask bit 100 = 0 -> CYCLE_FAIL only in cycle 2, FAIL_VEC=bit 7 only, FAIL_COUNT=1, FIRST_FAIL_CYCLE=2.
- Transfer on strobe cycle: EXP_TRANSFER with new value at phase==STROBE_EDGE -> that cycle compares against the old expected, the next cycle against the new; also LOAD+TRANSFER together moves the old pre-buffer.
- Boundaries: CYCLE_LENGTH=0, STROBE_EDGE=127 -> strobe every 256 CLKs; CYCLE_LENGTH=4, STROBE_EDGE=5 -> no RESULT_VALID ever; force FAIL_COUNT to saturate (CNT_W=4, 20 failing cycles) -> holds 4'hF.
- Run restart and mid-run reset: drop and re-raise PERFORM_TEST -> FAIL_VEC/counters cleared, buffers retained; RST mid-run -> immediate clear including buffers, phase 0.
